// File: rtl/prefetch_ifu_pkg.sv
// Shared defaults for the fetch path: instruction/address widths used by the core and the IFU.
// Also hosts small sizing helpers used by the prefetch queue.
package prefetch_ifu_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDepth = 4;

  // Bits needed to hold an occupancy count in the range 0..depth.
  function automatic int unsigned level_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prefetch_ifu_sync_fifo.sv
// Synchronous FIFO with registered head, single-cycle flush and occupancy count.
// No fall-through: a pushed entry becomes visible at the head in the following cycle.
module prefetch_ifu_sync_fifo
  import prefetch_ifu_pkg::*;
#(
  parameter int unsigned WIDTH = DefDataW + DefAddrW,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  input  logic                           flush,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [LvlW-1:0]  count_q, count_d;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + LvlW'(1);
        2'b01:   count_d = count_q - LvlW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      // Pointers are powers of two, so wrap is free; push is never issued when full.
      if (push && !flush) begin
        mem_q[wptr_q] <= wdata;
      end
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/prefetch_ifu.sv
// Instruction fetch unit: streams sequential reads from a 1-cycle-latency memory into a
// prefetch queue and hands them to the core via valid/ready; redirect flushes and restarts.
module prefetch_ifu
  import prefetch_ifu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       run,
  output logic                       imem_en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       instr_valid,
  output logic [DATA_W-1:0]          instr,
  output logic [ADDR_W-1:0]          instr_pc,
  input  logic                       instr_ready,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned LvlW   = level_w(DEPTH);
  localparam int unsigned CreditW = LvlW + 1;
  localparam int unsigned EntryW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

  logic               push, pop, issue;
  logic [EntryW-1:0]  head;
  logic [LvlW-1:0]    count;
  logic               empty;
  logic [CreditW-1:0] credit;

  assign instr_valid = ~empty;

  // Redirect wins over everything: no pop, no push of the returning read, no issue.
  assign pop  = instr_valid & instr_ready & ~redirect;
  assign push = inflight_q & ~redirect;

  // Occupancy including the outstanding read, net of this cycle's pop; a pop frees a slot
  // for an issue in the same cycle. pop implies count >= 1, so this cannot underflow.
  assign credit = CreditW'(count) + CreditW'(inflight_q) - CreditW'(pop);

  assign issue     = reset_n & run & ~redirect & (credit < CreditW'(DEPTH));
  assign imem_en   = issue;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  prefetch_ifu_sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({inflight_pc_q, imem_rdata}),
    .pop     (pop),
    .flush   (redirect),
    .rdata   (head),
    .count   (count),
    .empty   (empty)
  );

  assign instr    = instr_valid ? head[DATA_W-1:0] : '0;
  assign instr_pc = instr_valid ? head[EntryW-1:DATA_W] : '0;
  assign level    = count;

endmodule

// File: doc/prefetch_ifu.md
# prefetch_ifu

Parametrised instruction fetch unit with a prefetch queue. It decouples the instruction memory from the execution core. It streams sequential instructions from a synchronous-read instruction memory into a DEPTH-entry FIFO and presents them to the core through a valid/ready handshake. A redirect input flushes the queue and all in-flight reads, then restarts fetch at a new PC. It replaces the single-register, done-gated fetch path and sits between instruction memory and the core inside the top-level core wrapper.

## Interface
Parameters:
- DATA_W, 16, instruction width
- ADDR_W, 8, PC / instruction-memory address width
- DEPTH, 4, prefetch queue entries; power of two, ≥ 2

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  fetch enable; low stops new memory reads
- imem_en  out  1  memory read strobe
- imem_addr  out  ADDR_W  read address (= fetch PC)
- imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after an imem_en cycle
- instr_valid  out  1  queue head valid
- instr  out  DATA_W  queue head instruction; 0 when instr_valid = 0
- instr_pc  out  ADDR_W  address of queue head; 0 when instr_valid = 0
- instr_ready  in  1  core accepts head (pop when instr_valid & instr_ready)
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  restart address, sampled when redirect = 1
- level  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- Registers:
  - fetch_pc (reset 0)
  - inflight flag plus its captured PC (reset 0)
  - FIFO storage of {pc, instr}, read pointer, write pointer, count (all reset 0)
- Issue rule: imem_en = run & ~redirect & (count + inflight − pop < DEPTH). imem_addr = fetch_pc. On issue, fetch_pc ← fetch_pc + 1, wrapping modulo 2^ADDR_W (2^ADDR_W−1 → 0).
- Credit rule: count + inflight never exceeds DEPTH. Overflow is structurally impossible; no data is dropped.
- Return: in the cycle after an issue, {inflight_pc, imem_rdata} is pushed into the FIFO unless a redirect occurs in that same cycle.
- Pop: on instr_valid & instr_ready, the head is removed and the next entry is visible in the following cycle.
- Simultaneous push and pop: both take effect and count is unchanged. When the queue is empty, a push and a same-cycle pop cannot coincide, because the queue has no fall-through.
- Redirect has highest priority. In the redirect cycle:
  - the FIFO is emptied (count ← 0, pointers ← 0);
  - any returning read is discarded and inflight ← 0;
  - any pop is ignored;
  - fetch_pc ← redirect_pc;
  - imem_en = 0.
  
  Fetch resumes the next cycle if run = 1.
- run low: no new issues. An already-issued read still lands in the queue. Queue contents are retained and remain poppable.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). imem_en is forced to 0 while reset_n is low.

## Timing
- Reset values: imem_en 0, imem_addr 0, instr_valid 0, instr 0, instr_pc 0, level 0.
- Fetch latency: run sampled high in cycle N (queue empty) → imem_en = 1 in cycle N → data written at the end of cycle N+1 → instr_valid = 1 in cycle N+2.
- Throughput: 1 instruction/cycle sustained with run = 1 and instr_ready held high.
- Redirect in cycle R → imem_en = 1 with imem_addr = redirect_pc in cycle R+1 → first valid head in cycle R+3 at the earliest.
- Full: with level = DEPTH, imem_en = 0 until a pop occurs. A pop in cycle P allows an issue in the same cycle P.
- imem_en and imem_addr are combinational from registered state plus run/redirect/instr_ready. All other outputs come directly from registers.

## Structure
- Shared defines header: default DATA_W and ADDR_W, shared with the core.
- One sub-module, sync_fifo:
  - parametrised width (ADDR_W + DATA_W) and DEPTH;
  - ports push, pop, flush, count;
  - asynchronous active-low reset.
- The top level holds fetch_pc, the inflight tracking and the issue/credit logic.

## Test plan
- Reset then run = 1, ready = 1, memory[i] = 0x1000 + i → instr_valid rises in cycle 2. instr/instr_pc sequence is 0x1000/0, 0x1001/1, … with no gaps.
- ready = 0 with run = 1 → exactly DEPTH (4) reads issued, level = 4, imem_en = 0 afterwards. Release ready → entries pop in order with no loss or duplication.
- Redirect to 0x40 while the queue is full and a read is in flight → level = 0 next cycle, imem_addr = 0x40. The first instr_pc after that is 0x40, and no stale PCs appear.
- ADDR_W = 4, start at PC 14 → delivered PCs are 14, 15, 0, 1.
- run toggled 1→0 with one read in flight → that instruction is still delivered and no further imem_en occurs.
- reset_n asserted mid-stream → all outputs read 0 asynchronously. After release, fetch restarts at PC 0.
